bm_seq_ctrl: RTL and testbench

//  Pass/line sequencer for the block-matching engine. Per frame it steps lines x disparity phases (dphases),
//  32 disparities each. Drives buf_info and a 1-cycle start pulse to the BM calculator.

---
 rtl/bm_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bm_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_seq_ctrl.sv
// Pass/line sequencer for the block-matching engine: steps lines x disparity phases and hands each pass to the calculator.
// Optional per-pass watchdog is compiled in with `define BM_SEQ_TIMEOUT_EN.
module bm_seq_ctrl #(
    parameter int HGT_W       = 9,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             frame_start,
    input  logic [HGT_W-1:0] hgt,
    input  logic [8:0]       ndisp,
    input  logic             lr_rdy,
    input  logic             sad_rdy,
    input  logic             lr_done,
    input  logic             sad_done,
    output logic             calc_start,
    output logic [15:0]      buf_info,
    output logic             busy,
    output logic             frame_done,
    output logic [HGT_W-1:0] line_cnt,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_RUN,
        S_RETIRE,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic             bank, bank_n;
    logic [2:0]       dphase, dphase_n;
    logic [HGT_W-1:0] line_n;
    logic             lr_seen, lr_seen_n;
    logic             sad_seen, sad_seen_n;
    logic             load_info;
    logic [8:0]       ndisp_q, nd_in, cfg_ndisp;
    logic [HGT_W-1:0] hgt_q, hgt_in, cfg_hgt;
    logic [15:0]      info_n;

    // Descriptor of one pass, derived from its position in the frame and the frame geometry.
    function automatic logic [15:0] pack_info(input logic b, input logic [2:0] dp,
                                              input logic [HGT_W-1:0] ln,
                                              input logic [8:0] nd, input logic [HGT_W-1:0] h);
        logic [3:0] np;
        logic [9:0] rem;
        logic [5:0] pd;
        logic [1:0] op;
        logic       ld;
        np  = 4'(({1'b0, nd} + 10'd31) >> 5);
        ld  = ({1'b0, dp} == (np - 4'd1));
        rem = {1'b0, nd} - {2'b00, dp, 5'b00000};
        pd  = (rem >= 10'd32) ? 6'd32 : rem[5:0];
        op  = (np == 4'd1) ? 2'd1 : ((dp == 3'd0) ? 2'd2 : 2'd3);
        return {b, ld, (ln == '0), (ln == (h - HGT_W'(1))), {1'b0, dp}, pd, op};
    endfunction

    assign nd_in     = (ndisp == 9'd0) ? 9'd1 : ndisp;
    assign hgt_in    = (hgt == '0) ? HGT_W'(1) : hgt;
    assign cfg_ndisp = (state == S_IDLE) ? nd_in : ndisp_q;
    assign cfg_hgt   = (state == S_IDLE) ? hgt_in : hgt_q;
    assign info_n    = pack_info(bank_n, dphase_n, line_n, cfg_ndisp, cfg_hgt);

`ifdef BM_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == S_START)
            tmo_cnt <= '0;
        else if (state == S_RUN)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign err = timeout_hit;
`else
    assign err = 1'b0;
`endif

    // Pass sequencing; enb low overrides everything and drops back to IDLE with bank preserved.
    always_comb begin
        state_n    = state;
        bank_n     = bank;
        dphase_n   = dphase;
        line_n     = line_cnt;
        lr_seen_n  = lr_seen;
        sad_seen_n = sad_seen;
        load_info  = 1'b0;
`ifdef BM_SEQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (!enb) begin
            state_n    = S_IDLE;
            dphase_n   = '0;
            line_n     = '0;
            lr_seen_n  = 1'b0;
            sad_seen_n = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state_n   = S_WAIT;
                        dphase_n  = '0;
                        line_n    = '0;
                        load_info = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lr_rdy && (sad_rdy || buf_info[1:0] != 2'd3))
                        state_n = S_START;
                end
                S_START: begin
                    lr_seen_n  = lr_done;
                    sad_seen_n = sad_done;
                    state_n    = S_RUN;
                end
                S_RUN: begin
                    lr_seen_n  = lr_seen | lr_done;
                    sad_seen_n = sad_seen | sad_done;
                    if (lr_seen_n && (sad_seen_n || buf_info[1:0] != 2'd3)) begin
                        state_n = S_RETIRE;
                    end
`ifdef BM_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        timeout_hit = 1'b1;
                        state_n     = S_IDLE;
                        dphase_n    = '0;
                        line_n      = '0;
                    end
`endif
                end
                S_RETIRE: begin
                    if (!buf_info[14]) begin
                        dphase_n  = dphase + 3'd1;
                        state_n   = S_WAIT;
                        load_info = 1'b1;
                    end else begin
                        dphase_n = '0;
                        bank_n   = ~bank;
                        if (buf_info[12]) begin
                            state_n = S_DONE;
                        end else begin
                            line_n    = line_cnt + HGT_W'(1);
                            state_n   = S_WAIT;
                            load_info = 1'b1;
                        end
                    end
                end
                S_DONE: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bank     <= 1'b0;
            dphase   <= '0;
            line_cnt <= '0;
            lr_seen  <= 1'b0;
            sad_seen <= 1'b0;
            ndisp_q  <= '0;
            hgt_q    <= '0;
            buf_info <= '0;
        end else begin
            state    <= state_n;
            bank     <= bank_n;
            dphase   <= dphase_n;
            line_cnt <= line_n;
            lr_seen  <= lr_seen_n;
            sad_seen <= sad_seen_n;
            if (state == S_IDLE && frame_start && enb) begin
                ndisp_q <= nd_in;
                hgt_q   <= hgt_in;
            end
            if (load_info)
                buf_info <= info_n;
        end
    end

    assign calc_start = (state == S_START);
    assign busy       = (state inside {S_WAIT, S_START, S_RUN, S_RETIRE});
    assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_bm_seq_ctrl.sv
// Self-checking bench for bm_seq_ctrl: a frame-level pass model predicts every calc_start descriptor,
// with directed scenarios for gating, completion ordering, abort, reset and (if compiled) the watchdog.
module tb_bm_seq_ctrl;
    localparam int HGT_W = 9;

    logic             clk = 1'b0;
    logic             rst, enb, frame_start;
    logic [HGT_W-1:0] hgt;
    logic [8:0]       ndisp;
    logic             lr_rdy, sad_rdy, lr_done, sad_done;
    logic             calc_start, busy, frame_done, err;
    logic [15:0]      buf_info;
    logic [HGT_W-1:0] line_cnt;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    int          exp_line_q[$];
    logic [15:0] seen_info[$];
    bit          auto_resp = 0;
    int          resp_delay = 5;
    bit          expect_err = 0;
    int          model_bank = 0;
    logic        prev_cs = 1'b0;

    bm_seq_ctrl #(.HGT_W(HGT_W), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .enb(enb), .frame_start(frame_start), .hgt(hgt), .ndisp(ndisp),
        .lr_rdy(lr_rdy), .sad_rdy(sad_rdy), .lr_done(lr_done), .sad_done(sad_done),
        .calc_start(calc_start), .buf_info(buf_info), .busy(busy), .frame_done(frame_done),
        .line_cnt(line_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected pass list for a whole frame, built from the frame geometry alone.
    task automatic build_frame(int nd, int h);
        int nde, he, ndph, rem, pd, op, b;
        nde  = (nd == 0) ? 1 : nd;
        he   = (h == 0) ? 1 : h;
        ndph = (nde + 31) / 32;
        b    = model_bank;
        for (int ln = 0; ln < he; ln++) begin
            for (int d = 0; d < ndph; d++) begin
                rem = nde - 32 * d;
                pd  = (rem > 32) ? 32 : rem;
                op  = (ndph == 1) ? 1 : ((d == 0) ? 2 : 3);
                exp_q.push_back(16'((b << 15) | ((d == ndph - 1) << 14) | ((ln == 0) << 13) |
                                    ((ln == he - 1) << 12) | (d << 8) | (pd << 2) | op));
                exp_line_q.push_back(ln);
            end
            b = b ^ 1;
        end
        model_bank = b;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int nd, int h);
        build_frame(nd, h);
        ndisp       = 9'(nd);
        hgt         = HGT_W'(h);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_start(string name, int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!calc_start && n < max);
        checkOutput(name, 32'(calc_start), 32'd1);
    endtask

    task automatic wait_done(string name, int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < max);
        checkOutput(name, 32'(frame_done), 32'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        checkOutput({tag, "_calc_start"}, 32'(calc_start), 32'd0);
        checkOutput({tag, "_buf_info"}, 32'(buf_info), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Per-cycle compare against the pass model.
    always @(negedge clk) begin
        if (!rst) begin
            if (calc_start) begin
                start_cnt++;
                seen_info.push_back(buf_info);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start: got buf_info 0x%0h expected no pass", buf_info);
                end else begin
                    checkOutput("pass_buf_info", 32'(buf_info), 32'(exp_q.pop_front()));
                    checkOutput("pass_line_cnt", 32'(line_cnt), 32'(exp_line_q.pop_front()));
                    checkOutput("busy_at_start", 32'(busy), 32'd1);
                end
                checkOutput("calc_start_one_cycle", 32'(prev_cs), 32'd0);
            end
            if (frame_done) begin
                done_cnt++;
                checkOutput("frame_done_all_passes", 32'(exp_q.size()), 32'd0);
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
            if (!expect_err)
                checkOutput("err_quiet", 32'(err), 32'd0);
        end
        prev_cs = calc_start;
    end

    // Calculator stand-in: completes both halves of a pass a fixed delay after calc_start.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_resp && calc_start && !rst) begin
                repeat (resp_delay) @(posedge clk);
                #1;
                lr_done  = 1'b1;
                sad_done = 1'b1;
                @(posedge clk);
                #1;
                lr_done  = 1'b0;
                sad_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int s0, d0, base;
        rst = 1'b1; enb = 1'b0; frame_start = 1'b0; hgt = '0; ndisp = '0;
        lr_rdy = 1'b0; sad_rdy = 1'b0; lr_done = 1'b0; sad_done = 1'b0;
        step(2);
        @(negedge clk);
        check_reset_outputs("reset");
        step(1);
        rst = 1'b0;
        enb = 1'b1;
        step(2);

        // Two-phase disparity, two lines.
        lr_rdy = 1'b1; sad_rdy = 1'b1; auto_resp = 1; resp_delay = 5;
        base = seen_info.size(); s0 = start_cnt; d0 = done_cnt;
        applyStimulus(64, 2);
        wait_done("t1_frame_done", 200);
        step(3);
        checkOutput("t1_start_count", 32'(start_cnt - s0), 32'd4);
        checkOutput("t1_done_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("t1_info0", 32'(seen_info[base]), 32'h2082);
        checkOutput("t1_info1", 32'(seen_info[base+1]), 32'h6183);
        checkOutput("t1_info2", 32'(seen_info[base+2]), 32'h9082);
        checkOutput("t1_info3", 32'(seen_info[base+3]), 32'hD183);

        // Partial last phase, then single-phase frames.
        base = seen_info.size();
        applyStimulus(40, 1);
        wait_done("t2a_frame_done", 200);
        step(3);
        checkOutput("t2a_info0", 32'(seen_info[base]), 32'h3082);
        checkOutput("t2a_info1", 32'(seen_info[base+1]), 32'h7123);
        base = seen_info.size();
        applyStimulus(20, 2);
        wait_done("t2b_frame_done", 200);
        step(3);
        checkOutput("t2b_info0", 32'(seen_info[base]), 32'hE051);
        checkOutput("t2b_info1", 32'(seen_info[base+1]), 32'h5051);

        // SAD readiness gating and completion ordering, driven by hand.
        auto_resp = 0; sad_rdy = 1'b0;
        applyStimulus(64, 2);
        @(negedge clk);
        checkOutput("t3_latency_wait", 32'(calc_start), 32'd0);
        @(negedge clk);
        checkOutput("t3_latency_start", 32'(calc_start), 32'd1);
        step(1);
        lr_done = 1'b1; step(1); lr_done = 1'b0;
        s0 = start_cnt;
        step(10);
        checkOutput("t3_sad_gate_hold", 32'(start_cnt - s0), 32'd0);
        checkOutput("t3_busy_while_gated", 32'(busy), 32'd1);
        sad_rdy = 1'b1;
        wait_start("t3_sad_gate_release", 5);
        step(1);
        s0 = start_cnt;
        sad_done = 1'b1; step(1); sad_done = 1'b0;
        step(4);
        checkOutput("t3_sad_only_no_retire", 32'(start_cnt - s0), 32'd0);
        lr_done = 1'b1; step(1); lr_done = 1'b0;
        wait_start("t3_line1_p0", 10);
        step(1);
        lr_done = 1'b1; step(1); lr_done = 1'b0;
        wait_start("t3_line1_p1", 10);
        step(1);
        lr_done = 1'b1; sad_done = 1'b1; step(1); lr_done = 1'b0; sad_done = 1'b0;
        wait_done("t3_frame_done", 10);
        step(3);

        // Abort mid-RUN on line 3.
        auto_resp = 1;
        applyStimulus(32, 5);
        for (int i = 0; i < 4; i++) wait_start("t4_pass_start", 50);
        checkOutput("t4_abort_line", 32'(line_cnt), 32'd3);
        step(1);
        enb = 1'b0;
        d0  = done_cnt;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_abort_busy", 32'(busy), 32'd0);
        checkOutput("t4_abort_line_clr", 32'(line_cnt), 32'd0);
        exp_q.delete(); exp_line_q.delete();
        model_bank = 0;
        step(10);
        checkOutput("t4_abort_no_done", 32'(done_cnt - d0), 32'd0);
        enb = 1'b1;
        step(1);
        applyStimulus(32, 1);
        wait_start("t4_restart", 10);
        checkOutput("t4_restart_line", 32'(line_cnt), 32'd0);
        checkOutput("t4_restart_info", 32'(buf_info), 32'h7081);
        wait_done("t4_restart_done", 50);
        step(3);

        // frame_start while busy is ignored.
        s0 = start_cnt; d0 = done_cnt;
        applyStimulus(64, 2);
        wait_start("t5_first_start", 10);
        step(2);
        frame_start = 1'b1; step(1); frame_start = 1'b0;
        wait_done("t5_frame_done", 200);
        step(10);
        checkOutput("t5_ignored_start_count", 32'(start_cnt - s0), 32'd4);
        checkOutput("t5_ignored_done_count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset mid-RUN.
        applyStimulus(32, 1);
        wait_start("t5_rst_start", 10);
        step(1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async_rst");
        exp_q.delete(); exp_line_q.delete();
        model_bank = 0;
        step(2);
        rst = 1'b0;
        step(8);
        applyStimulus(20, 1);
        wait_start("t5_post_rst_start", 10);
        checkOutput("t5_post_rst_info", 32'(buf_info), 32'h7051);
        wait_done("t5_post_rst_done", 50);
        step(3);

`ifdef BM_SEQ_TIMEOUT_EN
        // Watchdog: no completion ever arrives.
        auto_resp = 0;
        d0 = done_cnt;
        applyStimulus(32, 1);
        wait_start("t6_start", 10);
        expect_err = 1;
        repeat (100) @(negedge clk);
        checkOutput("t6_err_pulse", 32'(err), 32'd1);
        @(negedge clk);
        checkOutput("t6_err_one_cycle", 32'(err), 32'd0);
        checkOutput("t6_busy_after_timeout", 32'(busy), 32'd0);
        checkOutput("t6_no_frame_done", 32'(done_cnt - d0), 32'd0);
        expect_err = 0;
        exp_q.delete(); exp_line_q.delete();
        model_bank = model_bank ^ 1;
        step(3);
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
